// File: rtl/config_stream_loader_if.sv
// Stream and configuration-write bundle of the configuration loader.
// The master side feeds the image; the slave side (the loader) writes the fabric registers.
interface config_stream_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_we;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, cfg_addr, cfg_data, cfg_we, busy, done, error
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, cfg_addr, cfg_data, cfg_we, busy, done, error
  );
endinterface

// File: rtl/config_stream_loader.sv
// Loads a configuration image from a valid/ready word stream into the fabric registers,
// then validates it against a trailing XOR checksum word and reports done or error.
module config_stream_loader #(
  parameter int NUM_WORDS = 15,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  config_stream_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] word_cnt;
  logic [DATA_W-1:0] csum;
  logic [ADDR_W-1:0] cfg_addr_q;
  logic [DATA_W-1:0] cfg_data_q;
  logic              cfg_we_q;
  logic              ready;
  logic              accept;
  logic              last_word;
  logic              load_start;
  logic              write_word;

  // Ready depends on state alone so the upstream never sees a combinational loop through valid.
  assign ready     = (state == LOAD) || (state == CHECK);
  assign accept    = bus.in_valid && ready;
  assign last_word = (word_cnt == ADDR_W'(NUM_WORDS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_start = 1'b0;
    write_word = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_next = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          write_word = 1'b1;
          if (last_word) begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        // The checksum word is compared, never written to the fabric.
        if (accept) begin
          state_next = (bus.in_data == csum) ? DONE : ERR;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt   <= '0;
      csum       <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      cfg_we_q   <= 1'b0;
    end else begin
      cfg_we_q <= 1'b0;
      if (load_start) begin
        word_cnt <= '0;
        csum     <= '0;
      end else if (write_word) begin
        cfg_addr_q <= word_cnt;
        cfg_data_q <= bus.in_data;
        cfg_we_q   <= 1'b1;
        csum       <= csum ^ bus.in_data;
        word_cnt   <= word_cnt + ADDR_W'(1);
      end
    end
  end

  assign bus.in_ready = ready;
  assign bus.busy     = ready;
  assign bus.done     = (state == DONE);
  assign bus.error    = (state == ERR);
  assign bus.cfg_addr = cfg_addr_q;
  assign bus.cfg_data = cfg_data_q;
  assign bus.cfg_we   = cfg_we_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Randomized scoreboard bench for config_stream_loader: the driver updates an image-level
// model and queues expected writes, and an independent monitor checks every cfg_we cycle.
module tb_config_stream_loader;

  localparam int NUM_WORDS = 15;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  config_stream_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  config_stream_loader #(
    .NUM_WORDS(NUM_WORDS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_q[$];
  int                cyc    = 0;
  int                n_vec  = 0;
  int                n_fail = 0;
  bit                mon_on = 1'b0;
  bit                mon_exp_we;
  wr_t               mon_e;

  // Image-level model: words accepted since the last start, and the verdict once complete.
  bit                m_active = 1'b0;
  bit                m_done   = 1'b0;
  bit                m_err    = 1'b0;
  logic [DATA_W-1:0] m_words[$];
  logic [DATA_W-1:0] img[NUM_WORDS];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] imageXor();
    logic [DATA_W-1:0] x;
    x = '0;
    for (int i = 0; i < NUM_WORDS; i++) x = x ^ img[i];
    return x;
  endfunction

  // One clock of stimulus: check status against the model, drive inputs, advance the model.
  task automatic applyStimulus(input bit rst, input bit st, input bit vld,
                               input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] x;
    @(negedge clock);
    if (mon_on) begin
      checkOutput("in_ready", bus.in_ready, m_active);
      checkOutput("busy", bus.busy, m_active);
      checkOutput("done", bus.done, m_done);
      checkOutput("error", bus.error, m_err);
    end
    reset        = rst;
    bus.start    = st;
    bus.in_valid = vld;
    bus.in_data  = data;
    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_words.delete();
    end else if (m_active && vld) begin
      if (m_words.size() < NUM_WORDS) begin
        exp_q.push_back('{cyc + 1, ADDR_W'(m_words.size()), data});
        m_words.push_back(data);
      end else begin
        x = '0;
        foreach (m_words[i]) x = x ^ m_words[i];
        m_done   = (x == data);
        m_err    = !m_done;
        m_active = 1'b0;
      end
    end else if (!m_active && st) begin
      m_active = 1'b1;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_words.delete();
    end
  endtask

  // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid.
  task automatic sendImage(input logic [DATA_W-1:0] csum, input int mode, input int start_at);
    int idx;
    int guard;
    bit v;
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    idx   = 0;
    guard = 0;
    while (idx <= NUM_WORDS && m_active && guard < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = guard[0];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      applyStimulus(1'b0, idx == start_at, v, (idx < NUM_WORDS) ? img[idx] : csum);
      if (v) idx++;
      guard++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      mon_exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      checkOutput("cfg_we", bus.cfg_we, mon_exp_we);
      if (mon_exp_we) begin
        mon_e = exp_q.pop_front();
        if (bus.cfg_we === 1'b1) begin
          checkOutput("cfg_addr", bus.cfg_addr, mon_e.addr);
          checkOutput("cfg_data", bus.cfg_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    @(negedge clock);
    checkOutput("rst_cfg_addr", bus.cfg_addr, 0);
    checkOutput("rst_cfg_data", bus.cfg_data, 0);
    checkOutput("rst_cfg_we", bus.cfg_we, 0);
    mon_on = 1'b1;

    // Incrementing image, streamed without stalls, then with every-other-cycle valid.
    for (int i = 0; i < NUM_WORDS; i++) img[i] = DATA_W'(i + 1);
    sendImage(imageXor(), 0, -1);
    sendImage(imageXor(), 1, -1);
    sendImage(32'h0000_0001, 0, -1);

    // All-ones image: wrong checksum first, then a reload with the right one.
    for (int i = 0; i < NUM_WORDS; i++) img[i] = 32'hFFFF_FFFF;
    sendImage(32'h0000_0000, 0, -1);
    sendImage(32'hFFFF_FFFF, 0, -1);

    // Abort after seven accepted words; valid stays high afterwards without a start.
    for (int i = 0; i < NUM_WORDS; i++) img[i] = $urandom;
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b1, img[i]);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, img[i]);

    // Start pulse while loading word 3 must not disturb the address sequence.
    sendImage(imageXor(), 0, 3);

    // Start coincident with reset: reset wins.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Adder image leading words.
    for (int i = 0; i < NUM_WORDS; i++) img[i] = $urandom;
    img[0] = 32'h9669_6996;
    img[1] = 32'h0000_0001;
    sendImage(imageXor(), 0, -1);

    // Random images with random stalls and randomly corrupted checksums.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NUM_WORDS; i++) img[i] = $urandom;
      sendImage(($urandom_range(0, 1) == 0) ? imageXor() : (imageXor() ^ DATA_W'(1 << $urandom_range(0, 31))),
                2, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, NUM_WORDS)));
    end

    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("write_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
